binary_search_ctrl: RTL and testbench

Sequential binary-search engine for the BSA datapath. It consumes the single-cycle `start` pulse from the upstream pulse-shaping stage and searches an external sorted synchronous RAM for `target`. It reports `found` and `loc`, and holds `done` until the next search. It drives the RAM read address directly and owns no storage beyond its search registers.

---
 rtl/bsa_pkg.sv | 16 +
 rtl/binary_search_ctrl.sv | 125 ++++++++++++
 tb/tb_binary_search_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bsa_pkg.sv
// Shared definitions for the BSA datapath: default widths and search FSM states.
package bsa_pkg;

  // Default word and address widths, shared with the RAM wrapper and top level.
  localparam int unsigned BSA_DATA_W = 8;
  localparam int unsigned BSA_ADDR_W = 5;

  // Search controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } bs_state_t;

endpackage

// File: rtl/binary_search_ctrl.sv
// Sequential binary-search engine over an external sorted synchronous RAM.
// One probe = FETCH (address presented) + CMP (read data compared).
module binary_search_ctrl
  import bsa_pkg::*;
#(
  parameter int unsigned DATA_W = BSA_DATA_W,
  parameter int unsigned ADDR_W = BSA_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] loc
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  bs_state_t         r_state;
  bs_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_lo;
  logic [ADDR_W-1:0] r_hi;
  logic [DATA_W-1:0] r_tgt;
  logic [ADDR_W-1:0] r_loc;
  logic              r_found;

  logic [ADDR_W-1:0] w_lo_nxt;
  logic [ADDR_W-1:0] w_hi_nxt;
  logic [DATA_W-1:0] w_tgt_nxt;
  logic [ADDR_W-1:0] w_loc_nxt;
  logic              w_found_nxt;

  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W-1:0] w_mid;

  // Midpoint computed one bit wider so lo+hi never overflows before the shift.
  always_comb begin
    w_sum = {1'b0, r_lo} + {1'b0, r_hi};
    w_mid = w_sum[ADDR_W:1];
  end

  // State and search registers; reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_tgt   <= '0;
      r_loc   <= '0;
      r_found <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_tgt   <= w_tgt_nxt;
      r_loc   <= w_loc_nxt;
      r_found <= w_found_nxt;
    end
  end

  // Next-state and search-register update.
  // Termination is decided by mid hitting the live bound instead of lo>hi,
  // so lo/hi never step outside 0..2**ADDR_W-1.
  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_tgt_nxt   = r_tgt;
    w_loc_nxt   = r_loc;
    w_found_nxt = r_found;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = FETCH;
          w_tgt_nxt   = target;
          w_lo_nxt    = '0;
          w_hi_nxt    = '1;
          w_found_nxt = 1'b0;
          w_loc_nxt   = '0;
        end
      end
      FETCH: begin
        w_state_nxt = CMP;
      end
      CMP: begin
        if (mem_rdata == r_tgt) begin
          w_found_nxt = 1'b1;
          w_loc_nxt   = w_mid;
          w_state_nxt = DONE;
        end else if (mem_rdata < r_tgt) begin
          if (w_mid == r_hi) begin
            w_state_nxt = DONE;
          end else begin
            w_lo_nxt    = w_mid + ADDR_ONE;
            w_state_nxt = FETCH;
          end
        end else begin
          if (w_mid == r_lo) begin
            w_state_nxt = DONE;
          end else begin
            w_hi_nxt    = w_mid - ADDR_ONE;
            w_state_nxt = FETCH;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Moore status outputs and RAM address.
  always_comb begin
    mem_addr = w_mid;
    busy     = (r_state == FETCH) || (r_state == CMP);
    done     = (r_state == DONE);
    found    = r_found;
    loc      = r_loc;
  end

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Scoreboard bench for binary_search_ctrl with a behavioural RAM and search model.
module tb_binary_search_ctrl;
  import bsa_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] target;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          busy, done, found;
  logic [AW-1:0] loc;

  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] tgt;
    bit            exp_found;
    int            exp_lat;
    int            start_cyc;
  } exp_t;

  exp_t sbq[$];

  binary_search_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .target    (target),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .loc       (loc)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: presence by linear scan; probe count by halving the interval.
  function automatic void model(input logic [DW-1:0] t, output bit f, output int probes);
    int lo, hi, mid;
    f = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] == t) f = 1'b1;
    lo = 0; hi = DEPTH - 1; probes = 0;
    while (1) begin
      probes++;
      mid = (lo + hi) / 2;
      if (mem[mid] == t) break;
      if (mem[mid] < t) begin
        if (mid == hi) break;
        lo = mid + 1;
      end else begin
        if (mid == lo) break;
        hi = mid - 1;
      end
    end
  endfunction

  // Pulse start for one cycle; optionally log the expected result.
  task automatic issue(input logic [DW-1:0] t, input bit push);
    exp_t e;
    int   k;
    @(posedge clk); #1;
    start  = 1'b1;
    target = t;
    @(posedge clk); #1;
    start  = 1'b0;
    if (push) begin
      e.tgt = t;
      model(t, e.exp_found, k);
      e.exp_lat   = 2 * k + 1;
      e.start_cyc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: done=%0d expected 1 within 40 cycles", name, done);
    end
  endtask

  // Monitor: on each rising done, pop the oldest expectation and compare.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: queue size 0 expected >0");
        end else begin
          e = sbq.pop_front();
          check("found", int'(found), int'(e.exp_found));
          if (found) check("mem_at_loc", int'(mem[loc]), int'(e.tgt));
          else       check("loc_zero", int'(loc), 0);
          check("latency", cyc - e.start_cyc + 1, e.exp_lat);
          check("busy_at_done", int'(busy), 0);
        end
      end
      prev = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] t;
    reset = 1'b1; start = 1'b0; target = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(2 * i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_loc", int'(loc), 0);
    check("rst_addr", int'(mem_addr), 0);
    reset = 1'b0;

    // Directed searches on mem[i] = 2*i.
    issue(8'd30, 1'b1); wait_done("t30");
    check("t30_loc", int'(loc), 15);
    issue(8'd20, 1'b1);
    check("restart_done_drop", int'(done), 0);
    check("restart_busy_rise", int'(busy), 1);
    wait_done("t20");
    check("t20_loc", int'(loc), 10);
    issue(8'd0, 1'b1);   wait_done("t0");   check("t0_loc", int'(loc), 0);
    issue(8'd62, 1'b1);  wait_done("t62");  check("t62_loc", int'(loc), 31);
    issue(8'd21, 1'b1);  wait_done("t21");  check("t21_found", int'(found), 0);
    issue(8'd255, 1'b1); wait_done("t255"); check("t255_found", int'(found), 0);

    // Extra start pulses and target changes mid-search are ignored.
    issue(8'd20, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start  = 1'b1;
      target = DW'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore");
    check("ignore_loc", int'(loc), 10);

    // Reset during CMP.
    issue(8'd255, 1'b0);
    @(posedge clk); #1;
    check("cmp_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_found", int'(found), 0);
    check("midrst_loc", int'(loc), 0);
    check("midrst_addr", int'(mem_addr), 0);
    reset = 1'b0;
    issue(8'd40, 1'b1); wait_done("t40");
    check("t40_loc", int'(loc), 20);

    // Random sorted contents (with duplicates) and random targets.
    for (int it = 0; it < 40; it++) begin
      @(negedge clk); #1;
      v = '0;
      for (int i = 0; i < DEPTH; i++) begin
        v = v + DW'($urandom_range(0, 7));
        mem[i] = v;
      end
      if ($urandom_range(0, 1) == 1) begin
        v = mem[$urandom_range(0, DEPTH - 1)];
        t = v;
      end else begin
        t = DW'($urandom_range(0, 255));
      end
      issue(t, 1'b1);
      wait_done("rand");
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
